systolic_operand_skewer: RTL and testbench

//  Parametrised operand front-end for the PE_ROWS x PE_COLS systolic matmul array. It accepts one
//  A tile (PE_ROWS x K, row-major) and one B tile (K x PE_COLS, k-major) as serial valid/ready

---
 rtl/systolic_operand_skewer_pkg.sv | 23 ++
 rtl/systolic_operand_skewer_if.sv | 33 +++
 rtl/systolic_operand_skewer_skew_lane.sv | 20 ++
 rtl/systolic_operand_skewer.sv | 190 +++++++++++++++++++
 tb/tb_systolic_operand_skewer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/systolic_operand_skewer_pkg.sv
// Shared types and helpers for the systolic operand skewer: FSM state encoding,
// lane geometry helpers and the default array diagonal length.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } skew_state_e;

  function automatic int max_dim(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Wavefront length of the default 4x4 array; modules derive their own from parameters.
  localparam int M = max_dim(4, 4);

endpackage

// File: rtl/systolic_operand_skewer_if.sv
// Load streams, configuration and skewed lane outputs of the operand skewer.
interface systolic_operand_skewer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_ROWS    = 4,
  parameter int PE_COLS    = 4,
  parameter int K_MAX      = 64
);
  logic                                start;
  logic [$clog2(K_MAX+1)-1:0]          cfg_k;
  logic signed [DATA_WIDTH-1:0]        a_data;
  logic                                a_valid;
  logic                                a_ready;
  logic signed [DATA_WIDTH-1:0]        b_data;
  logic                                b_valid;
  logic                                b_ready;
  logic [PE_ROWS*DATA_WIDTH-1:0]       a_out;
  logic [PE_ROWS-1:0]                  a_out_valid;
  logic [PE_COLS*DATA_WIDTH-1:0]       b_out;
  logic [PE_COLS-1:0]                  b_out_valid;
  logic                                busy;
  logic                                done;
  logic                                err_cfg;

  modport slave (
    input  start, cfg_k, a_data, a_valid, b_data, b_valid,
    output a_ready, b_ready, a_out, a_out_valid, b_out, b_out_valid, busy, done, err_cfg
  );

  modport master (
    output start, cfg_k, a_data, a_valid, b_data, b_valid,
    input  a_ready, b_ready, a_out, a_out_valid, b_out, b_out_valid, busy, done, err_cfg
  );
endinterface

// File: rtl/systolic_operand_skewer_skew_lane.sv
// One skew lane: lane LANE is live for steps LANE..LANE+K-1 and reads element t-LANE.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int CW   = 9,
  parameter int KW   = 7,
  parameter int IW   = 6,
  parameter int LANE = 0
) (
  input  logic [CW-1:0] t,
  input  logic [KW-1:0] k,
  output logic          vld,
  output logic [IW-1:0] idx
);
  logic [CW-1:0] rel;

  assign rel = t - CW'(LANE);
  assign vld = (t >= CW'(LANE)) && (rel < CW'(k));
  assign idx = IW'(rel);
endmodule

// File: rtl/systolic_operand_skewer.sv
// Buffers one A and one B tile from serial streams, then replays them as
// diagonally skewed per-lane wavefronts followed by a drain period and done pulse.
module systolic_operand_skewer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PE_ROWS      = 4,
  parameter int PE_COLS      = 4,
  parameter int K_MAX        = 64,
  parameter int DRAIN_CYCLES = PE_ROWS + PE_COLS
) (
  input logic                      clk,
  input logic                      rst_n,
  systolic_operand_skewer_if.slave bus
);
  localparam int M_DIM = max_dim(PE_ROWS, PE_COLS);
  localparam int CW    = $clog2(M_DIM*K_MAX + 1);
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int RW    = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
  localparam int LW    = (PE_COLS > 1) ? $clog2(PE_COLS) : 1;
  localparam int DW    = $clog2(DRAIN_CYCLES + 1);

  skew_state_e   state, state_nxt;
  logic [KW-1:0] k_q;
  logic [CW-1:0] a_cnt, b_cnt, step_q;
  logic [RW-1:0] a_row;
  logic [IW-1:0] a_col, b_k;
  logic [LW-1:0] b_col;
  logic [DW-1:0] drain_cnt;
  logic          done_q, err_q;

  logic signed [DATA_WIDTH-1:0] a_buf [PE_ROWS][K_MAX];
  logic signed [DATA_WIDTH-1:0] b_buf [K_MAX][PE_COLS];

  logic          cfg_legal, take_start;
  logic          a_acc, b_acc, a_fin, b_fin, load_fin, emit;
  logic [CW-1:0] a_total, b_total, last_step, t_sel;

  assign cfg_legal  = (bus.cfg_k != '0) && (bus.cfg_k <= KW'(K_MAX));
  assign take_start = (state == IDLE) && bus.start;
  assign a_total    = CW'(PE_ROWS) * CW'(k_q);
  assign b_total    = CW'(PE_COLS) * CW'(k_q);
  assign last_step  = CW'(k_q) + CW'(M_DIM - 1);

  assign bus.a_ready = (state == LOAD) && (a_cnt != a_total);
  assign bus.b_ready = (state == LOAD) && (b_cnt != b_total);
  assign a_acc       = bus.a_valid && bus.a_ready;
  assign b_acc       = bus.b_valid && bus.b_ready;

  // Completion looks one accept ahead so the step-0 wavefront is registered in cycle F.
  assign a_fin    = (a_cnt == a_total) || (a_acc && (a_cnt == a_total - 1'b1));
  assign b_fin    = (b_cnt == b_total) || (b_acc && (b_cnt == b_total - 1'b1));
  assign load_fin = a_fin && b_fin;
  assign emit     = ((state == LOAD) && load_fin) || (state == FEED);
  assign t_sel    = (state == FEED) ? step_q : '0;

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.err_cfg = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_start && cfg_legal) state_nxt = LOAD;
      LOAD:    if (load_fin)                state_nxt = FEED;
      FEED:    if (step_q == last_step)     state_nxt = DRAIN;
      DRAIN:   if (done_q)                  state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      a_row     <= '0;
      a_col     <= '0;
      b_k       <= '0;
      b_col     <= '0;
      step_q    <= '0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= take_start && !cfg_legal;
      done_q <= (state == DRAIN) && !done_q && (drain_cnt == DW'(DRAIN_CYCLES - 1));
      if (take_start && cfg_legal) begin
        k_q   <= bus.cfg_k;
        a_cnt <= '0;
        b_cnt <= '0;
        a_row <= '0;
        a_col <= '0;
        b_k   <= '0;
        b_col <= '0;
      end
      if (a_acc) begin
        a_cnt <= a_cnt + 1'b1;
        if (a_col == IW'(k_q - 1'b1)) begin
          a_col <= '0;
          a_row <= a_row + 1'b1;
        end else begin
          a_col <= a_col + 1'b1;
        end
      end
      if (b_acc) begin
        b_cnt <= b_cnt + 1'b1;
        if (b_col == LW'(PE_COLS - 1)) begin
          b_col <= '0;
          b_k   <= b_k + 1'b1;
        end else begin
          b_col <= b_col + 1'b1;
        end
      end
      if ((state == LOAD) && load_fin) step_q <= CW'(1);
      else if (state == FEED)          step_q <= step_q + 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (a_acc) a_buf[a_row][a_col] <= bus.a_data;
    if (b_acc) b_buf[b_k][b_col]   <= bus.b_data;
  end

  logic [PE_ROWS-1:0]            a_lv;
  logic [PE_COLS-1:0]            b_lv;
  logic [IW-1:0]                 a_idx [PE_ROWS];
  logic [IW-1:0]                 b_idx [PE_COLS];
  logic [PE_ROWS*DATA_WIDTH-1:0] a_nxt;
  logic [PE_COLS*DATA_WIDTH-1:0] b_nxt;

  for (genvar r = 0; r < PE_ROWS; r++) begin : g_a_lane
    skew_lane #(.CW(CW), .KW(KW), .IW(IW), .LANE(r)) u_lane (
      .t(t_sel), .k(k_q), .vld(a_lv[r]), .idx(a_idx[r])
    );
  end

  for (genvar c = 0; c < PE_COLS; c++) begin : g_b_lane
    skew_lane #(.CW(CW), .KW(KW), .IW(IW), .LANE(c)) u_lane (
      .t(t_sel), .k(k_q), .vld(b_lv[c]), .idx(b_idx[c])
    );
  end

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int r = 0; r < PE_ROWS; r++)
      if (a_lv[r]) a_nxt[lane_lo(r, DATA_WIDTH) +: DATA_WIDTH] = a_buf[r][a_idx[r]];
    for (int c = 0; c < PE_COLS; c++)
      if (b_lv[c]) b_nxt[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH] = b_buf[b_idx[c]][c];
  end

  // Output stage: lane data and valids registered together.
  logic [PE_ROWS*DATA_WIDTH-1:0] a_out_p1;
  logic [PE_COLS*DATA_WIDTH-1:0] b_out_p1;
  logic [PE_ROWS-1:0]            a_vld_p1;
  logic [PE_COLS-1:0]            b_vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_p1 <= '0;
      b_out_p1 <= '0;
      a_vld_p1 <= '0;
      b_vld_p1 <= '0;
    end else if (emit) begin
      a_out_p1 <= a_nxt;
      b_out_p1 <= b_nxt;
      a_vld_p1 <= a_lv;
      b_vld_p1 <= b_lv;
    end else begin
      a_out_p1 <= '0;
      b_out_p1 <= '0;
      a_vld_p1 <= '0;
      b_vld_p1 <= '0;
    end
  end

  assign bus.a_out       = a_out_p1;
  assign bus.b_out       = b_out_p1;
  assign bus.a_out_valid = a_vld_p1;
  assign bus.b_out_valid = b_vld_p1;
endmodule

// File: tb/tb_systolic_operand_skewer.sv
// Randomised bench for the operand skewer: a per-cycle monitor compares every output
// against a tile model built from the stream order and the skew formula.
module tb_systolic_operand_skewer;
  localparam int DW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KM = 64;
  localparam int MM = 4;
  localparam int DC = R + C;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  systolic_operand_skewer_if #(.DATA_WIDTH(DW), .PE_ROWS(R), .PE_COLS(C), .K_MAX(KM)) bus ();

  systolic_operand_skewer #(
    .DATA_WIDTH(DW), .PE_ROWS(R), .PE_COLS(C), .K_MAX(KM), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [DW-1:0] a_stream [R*KM];
  logic [DW-1:0] b_stream [C*KM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: 0 idle, 1 loading, 2 replaying/draining until the done cycle.
  int            m_phase = 0;
  int            m_k, m_na, m_nb, m_f;
  int            m_err_due = -1;
  int            t;
  logic [3:0]    e_av, e_bv;
  logic [63:0]   e_a, e_b;
  logic          e_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
      chk("rst_err", 64'(bus.err_cfg), 0);
      chk("rst_ardy", 64'(bus.a_ready), 0);
      chk("rst_brdy", 64'(bus.b_ready), 0);
      chk("rst_avld", 64'(bus.a_out_valid), 0);
      chk("rst_bvld", 64'(bus.b_out_valid), 0);
      chk("rst_aout", bus.a_out, 0);
      chk("rst_bout", bus.b_out, 0);
      m_phase   = 0;
      m_err_due = -1;
    end else begin
      e_av = '0; e_bv = '0; e_a = '0; e_b = '0; e_done = 1'b0;
      if (m_phase == 2) begin
        t = cyc - m_f - 1;
        for (int r = 0; r < R; r++)
          if (t >= r && t < r + m_k) begin
            e_av[r] = 1'b1;
            e_a[r*DW +: DW] = a_stream[r*m_k + (t - r)];
          end
        for (int c = 0; c < C; c++)
          if (t >= c && t < c + m_k) begin
            e_bv[c] = 1'b1;
            e_b[c*DW +: DW] = b_stream[(t - c)*C + c];
          end
        e_done = (cyc == m_f + m_k + MM + DC);
      end
      chk("busy", 64'(bus.busy), 64'(m_phase != 0));
      chk("a_ready", 64'(bus.a_ready), 64'(m_phase == 1 && m_na < R*m_k));
      chk("b_ready", 64'(bus.b_ready), 64'(m_phase == 1 && m_nb < C*m_k));
      chk("err_cfg", 64'(bus.err_cfg), 64'(cyc == m_err_due));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("a_vld", 64'(bus.a_out_valid), 64'(e_av));
      chk("a_out", bus.a_out, e_a);
      chk("b_vld", 64'(bus.b_out_valid), 64'(e_bv));
      chk("b_out", bus.b_out, e_b);
      case (m_phase)
        0: if (bus.start) begin
             if (bus.cfg_k >= 1 && bus.cfg_k <= KM) begin
               m_phase = 1; m_k = int'(bus.cfg_k); m_na = 0; m_nb = 0;
             end else begin
               m_err_due = cyc + 1;
             end
           end
        1: begin
             if (bus.a_valid && bus.a_ready) m_na++;
             if (bus.b_valid && bus.b_ready) m_nb++;
             if (m_na == R*m_k && m_nb == C*m_k) begin
               m_f = cyc; m_phase = 2;
             end
           end
        default: if (e_done) m_phase = 0;
      endcase
    end
  end

  // pct < 0 gives a strict 1/0 toggle on valid; otherwise pct is the stall percentage.
  task automatic drive_a(input int n, input int pct);
    int i = 0, g = 0;
    logic acc;
    while (i < n && g < 4000) begin
      bus.a_valid = (pct < 0) ? (g % 2 == 0) : (int'($urandom_range(0, 99)) >= pct);
      bus.a_data  = a_stream[i];
      @(negedge clk); acc = bus.a_valid && bus.a_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    bus.a_valid = 1'b0;
    if (i < n) chk("a_load_timeout", 64'(i), 64'(n));
  endtask

  task automatic drive_b(input int n, input int pct);
    int i = 0, g = 0;
    logic acc;
    while (i < n && g < 4000) begin
      bus.b_valid = (pct < 0) ? (g % 2 == 0) : (int'($urandom_range(0, 99)) >= pct);
      bus.b_data  = b_stream[i];
      @(negedge clk); acc = bus.b_valid && bus.b_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    bus.b_valid = 1'b0;
    if (i < n) chk("b_load_timeout", 64'(i), 64'(n));
  endtask

  task automatic run_tile(input int k, input bit seq, input int apct, input int bpct,
                          input bit poke, input int abort);
    int g = 0;
    for (int i = 0; i < R*k; i++) a_stream[i] = seq ? DW'(i + 1)   : DW'($urandom);
    for (int i = 0; i < C*k; i++) b_stream[i] = seq ? DW'(i + 101) : DW'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_k = 7'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cfg_k = 7'($urandom_range(0, 127));
    fork
      drive_a(R*k, apct);
      drive_b(C*k, bpct);
    join
    if (abort > 0) begin
      repeat (abort) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      if (poke) begin
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.cfg_k = 7'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      do begin
        @(negedge clk);
        g++;
      end while (!bus.done && g < 400);
      if (!bus.done) chk("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic bad_cfg(input int k);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_k = 7'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.cfg_k   = '0;
    bus.a_data  = '0;
    bus.a_valid = 1'b0;
    bus.b_data  = '0;
    bus.b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run_tile(4, 1'b1, 0, 0, 1'b0, 0);
    run_tile(4, 1'b1, -1, 0, 1'b0, 0);
    bad_cfg(0);
    bad_cfg(65);
    run_tile(int'($urandom_range(2, 12)), 1'b0, 20, 20, 1'b1, 0);
    run_tile(6, 1'b0, 0, 0, 1'b0, 3);
    run_tile(1, 1'b0, 0, 0, 1'b0, 0);
    run_tile(64, 1'b0, 10, 30, 1'b0, 0);
    for (int n = 0; n < 6; n++)
      run_tile(int'($urandom_range(1, 64)), 1'b0, int'($urandom_range(0, 60)),
               int'($urandom_range(0, 60)), n[0], 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
